// File: rtl/uart_fifo_core.sv
// Full-duplex UART with a shared 16x oversampling tick, configurable frame format,
// first-word-fall-through TX/RX FIFOs and sticky parity/framing/overrun flags.
module uart_fifo_core #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_wr_en,
  input  logic [DATA_BITS-1:0]          tx_wr_data,
  output logic                          tx_full,
  output logic                          tx_busy,
  output logic                          tx,
  input  logic                          rx,
  input  logic                          rx_rd_en,
  output logic [DATA_BITS-1:0]          rx_rd_data,
  output logic                          rx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun_err,
  input  logic                          err_clr
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (PARITY_MODE == 2) ? ~(^d) : ^d;
  endfunction

  // Oversampling tick shared by both directions
  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  assign tick = (tick_cnt_q == TW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
  end

  // TX FIFO
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wptr_q, tx_rptr_q;
  logic                 tx_empty, tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                    (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
  assign tx_push  = tx_wr_en && (!tx_full || tx_pop);
  assign tx_head  = tx_mem[tx_rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= tx_wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
    end
  end

  // TX FSM
  state_e               tx_state_q;
  logic [3:0]           tx_cnt_q;
  logic [2:0]           tx_bit_q;
  logic                 tx_stop2_q;
  logic [DATA_BITS-1:0] tx_shreg_q;
  logic                 tx_par_q;
  logic                 tx_q;
  logic                 tx_last_stop;

  assign tx_last_stop = (STOP_BITS == 1) || tx_stop2_q;
  // The last stop tick may reload directly so frames run back-to-back
  assign tx_pop = tick && !tx_empty &&
                  ((tx_state_q == StIdle) ||
                   ((tx_state_q == StStop) && (tx_cnt_q == 4'd15) && tx_last_stop));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_stop2_q <= 1'b0;
      tx_shreg_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else if (tick) begin
      if (tx_state_q == StIdle) begin
        if (tx_pop) begin
          tx_shreg_q <= tx_head;
          tx_par_q   <= par_of(tx_head);
          tx_q       <= 1'b0;
          tx_cnt_q   <= '0;
          tx_state_q <= StStart;
        end
      end else if (tx_cnt_q != 4'd15) begin
        tx_cnt_q <= tx_cnt_q + 4'd1;
      end else begin
        tx_cnt_q <= '0;
        case (tx_state_q)
          StStart: begin
            tx_state_q <= StData;
            tx_q       <= tx_shreg_q[0];
            tx_shreg_q <= tx_shreg_q >> 1;
            tx_bit_q   <= '0;
          end
          StData: begin
            if (tx_bit_q == 3'(DATA_BITS - 1)) begin
              if (PARITY_MODE != 0) begin
                tx_state_q <= StParity;
                tx_q       <= tx_par_q;
              end else begin
                tx_state_q <= StStop;
                tx_q       <= 1'b1;
                tx_stop2_q <= 1'b0;
              end
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_q       <= tx_shreg_q[0];
              tx_shreg_q <= tx_shreg_q >> 1;
            end
          end
          StParity: begin
            tx_state_q <= StStop;
            tx_q       <= 1'b1;
            tx_stop2_q <= 1'b0;
          end
          StStop: begin
            if (!tx_last_stop) begin
              tx_stop2_q <= 1'b1;
            end else if (tx_pop) begin
              tx_shreg_q <= tx_head;
              tx_par_q   <= par_of(tx_head);
              tx_q       <= 1'b0;
              tx_state_q <= StStart;
            end else begin
              tx_state_q <= StIdle;
            end
          end
          default: tx_state_q <= StIdle;
        endcase
      end
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (tx_state_q != StIdle) || !tx_empty;

  // RX synchronizer and start-edge detect
  logic rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic rx_line, rx_fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_sync1_q <= rx;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
    end
  end

  assign rx_line = rx_sync2_q;
  assign rx_fall = rx_prev_q & ~rx_sync2_q;

  // RX FSM
  state_e               rx_state_q;
  logic [3:0]           rx_cnt_q;
  logic [2:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_shreg_q;
  logic                 rx_sample;

  assign rx_sample = tick && (rx_cnt_q == 4'd15);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shreg_q <= '0;
    end else if (rx_state_q == StIdle) begin
      if (rx_fall) begin
        rx_cnt_q   <= '0;
        rx_state_q <= StStart;
      end
    end else if (tick) begin
      if (rx_state_q == StStart) begin
        if (rx_cnt_q == 4'd7) begin
          rx_cnt_q   <= '0;
          rx_bit_q   <= '0;
          rx_state_q <= rx_line ? StIdle : StData;
        end else begin
          rx_cnt_q <= rx_cnt_q + 4'd1;
        end
      end else if (rx_cnt_q != 4'd15) begin
        rx_cnt_q <= rx_cnt_q + 4'd1;
      end else begin
        rx_cnt_q <= '0;
        case (rx_state_q)
          StData: begin
            rx_shreg_q <= {rx_line, rx_shreg_q[DATA_BITS-1:1]};
            if (rx_bit_q == 3'(DATA_BITS - 1)) begin
              rx_state_q <= (PARITY_MODE != 0) ? StParity : StStop;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end
          StParity: rx_state_q <= StStop;
          default:  rx_state_q <= StIdle;
        endcase
      end
    end
  end

  // RX FIFO
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]          rx_wptr_q, rx_rptr_q;
  logic                 rx_full, rx_push, rx_wr, rx_pop;
  logic                 parity_evt, frame_evt, overrun_evt;

  assign rx_push     = (rx_state_q == StStop) && rx_sample;
  assign parity_evt  = (rx_state_q == StParity) && rx_sample && (rx_line != par_of(rx_shreg_q));
  assign frame_evt   = rx_push && !rx_line;
  assign rx_empty    = (rx_wptr_q == rx_rptr_q);
  assign rx_full     = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                       (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
  assign rx_pop      = rx_rd_en && !rx_empty;
  assign rx_wr       = rx_push && (!rx_full || rx_pop);
  assign overrun_evt = rx_push && rx_full && !rx_rd_en;
  assign rx_count    = rx_wptr_q - rx_rptr_q;
  assign rx_rd_data  = rx_empty ? '0 : rx_mem[rx_rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wptr_q[AW-1:0]] <= rx_shreg_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
    end else begin
      if (rx_wr)  rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop) rx_rptr_q <= rx_rptr_q + 1'b1;
    end
  end

  // Sticky flags: a same-cycle error event beats err_clr
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      parity_err  <= (parity_err  & ~err_clr) | parity_evt;
      frame_err   <= (frame_err   & ~err_clr) | frame_evt;
      overrun_err <= (overrun_err & ~err_clr) | overrun_evt;
    end
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed self-checking bench for uart_fifo_core: three frame formats, loopback and
// bench-driven serial frames, FIFO limits and mid-frame reset.
module tb_uart_fifo_core;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // sel picks which instance the bench talks to: 0 = 8N1/depth 4, 1 = 7E2, 2 = 7O2
  logic [1:0] sel;
  logic       drv_en, drv, wr_en, rd_en, err_clr;
  logic [7:0] wr_data;

  logic       tx_full_a, tx_busy_a, tx_a, rx_a, rx_empty_a, pe_a, fe_a, oe_a;
  logic [7:0] rd_a;
  logic [2:0] cnt_a;
  logic       tx_full_b, tx_busy_b, tx_b, rx_b, rx_empty_b, pe_b, fe_b, oe_b;
  logic [6:0] rd_b;
  logic [4:0] cnt_b;
  logic       tx_full_c, tx_busy_c, tx_c, rx_c, rx_empty_c, pe_c, fe_c, oe_c;
  logic [6:0] rd_c;
  logic [4:0] cnt_c;

  assign rx_a = (drv_en && sel == 2'd0) ? drv : tx_a;
  assign rx_b = tx_b;
  assign rx_c = (drv_en && sel == 2'd2) ? drv : tx_c;

  uart_fifo_core #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                   .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .tx_wr_en(wr_en && sel == 2'd0), .tx_wr_data(wr_data),
    .tx_full(tx_full_a), .tx_busy(tx_busy_a), .tx(tx_a), .rx(rx_a),
    .rx_rd_en(rd_en && sel == 2'd0), .rx_rd_data(rd_a), .rx_empty(rx_empty_a),
    .rx_count(cnt_a), .parity_err(pe_a), .frame_err(fe_a), .overrun_err(oe_a),
    .err_clr(err_clr)
  );

  uart_fifo_core #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(7),
                   .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(16)) u_b (
    .clk(clk), .reset(reset), .tx_wr_en(wr_en && sel == 2'd1), .tx_wr_data(wr_data[6:0]),
    .tx_full(tx_full_b), .tx_busy(tx_busy_b), .tx(tx_b), .rx(rx_b),
    .rx_rd_en(rd_en && sel == 2'd1), .rx_rd_data(rd_b), .rx_empty(rx_empty_b),
    .rx_count(cnt_b), .parity_err(pe_b), .frame_err(fe_b), .overrun_err(oe_b),
    .err_clr(err_clr)
  );

  uart_fifo_core #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(7),
                   .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(16)) u_c (
    .clk(clk), .reset(reset), .tx_wr_en(wr_en && sel == 2'd2), .tx_wr_data(wr_data[6:0]),
    .tx_full(tx_full_c), .tx_busy(tx_busy_c), .tx(tx_c), .rx(rx_c),
    .rx_rd_en(rd_en && sel == 2'd2), .rx_rd_data(rd_c), .rx_empty(rx_empty_c),
    .rx_count(cnt_c), .parity_err(pe_c), .frame_err(fe_c), .overrun_err(oe_c),
    .err_clr(err_clr)
  );

  logic       tx_v, busy_v, full_v, empty_v, pe_v, fe_v, oe_v;
  logic [7:0] rd_v;
  logic [4:0] cnt_v;

  assign tx_v    = (sel == 2'd0) ? tx_a       : (sel == 2'd1) ? tx_b       : tx_c;
  assign busy_v  = (sel == 2'd0) ? tx_busy_a  : (sel == 2'd1) ? tx_busy_b  : tx_busy_c;
  assign full_v  = (sel == 2'd0) ? tx_full_a  : (sel == 2'd1) ? tx_full_b  : tx_full_c;
  assign empty_v = (sel == 2'd0) ? rx_empty_a : (sel == 2'd1) ? rx_empty_b : rx_empty_c;
  assign pe_v    = (sel == 2'd0) ? pe_a       : (sel == 2'd1) ? pe_b       : pe_c;
  assign fe_v    = (sel == 2'd0) ? fe_a       : (sel == 2'd1) ? fe_b       : fe_c;
  assign oe_v    = (sel == 2'd0) ? oe_a       : (sel == 2'd1) ? oe_b       : oe_c;
  assign rd_v    = (sel == 2'd0) ? rd_a : (sel == 2'd1) ? {1'b0, rd_b} : {1'b0, rd_c};
  assign cnt_v   = (sel == 2'd0) ? {2'b00, cnt_a} : (sel == 2'd1) ? cnt_b : cnt_c;

  task automatic push(input logic [7:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Waits for the next start bit on tx, returning just after it falls
  task automatic find_start(input string name);
    int k = 0;
    while (tx_v !== 1'b0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (tx_v !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_start_timeout: tx=%b required 0", name, tx_v);
    end
  endtask

  // Starting at a bit mid-point, checks n consecutive bit cells of tx
  task automatic check_bits(input logic [11:0] bits, input int n, input string name);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (16) @(negedge clk);
      n_cmp++;
      if (tx_v !== bits[i]) begin
        n_bad++;
        $display("FAIL %s_bit%0d: tx=%b required %b", name, i, tx_v, bits[i]);
      end
    end
  endtask

  task automatic pop_check(input logic [7:0] exp, input string name);
    int k = 0;
    while (empty_v && k < 600) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (empty_v !== 1'b0 || rd_v !== exp) begin
      n_bad++;
      $display("FAIL %s: empty=%b data=%h required empty=0 data=%h", name, empty_v, rd_v, exp);
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic drive_bits(input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      drv = bits[i];
      repeat (16) @(negedge clk);
    end
    drv = 1'b1;
  endtask

  task automatic test_reset();
    sel = 2'd0;
    reset = 1'b0;
    #23;
    n_cmp++; if (tx_a !== 1'b1)       begin n_bad++; $display("FAIL rst_tx: %b required 1", tx_a); end
    n_cmp++; if (tx_full_a !== 1'b0)  begin n_bad++; $display("FAIL rst_full: %b required 0", tx_full_a); end
    n_cmp++; if (tx_busy_a !== 1'b0)  begin n_bad++; $display("FAIL rst_busy: %b required 0", tx_busy_a); end
    n_cmp++; if (rx_empty_a !== 1'b1) begin n_bad++; $display("FAIL rst_empty: %b required 1", rx_empty_a); end
    n_cmp++; if (cnt_a !== 3'd0)      begin n_bad++; $display("FAIL rst_count: %0d required 0", cnt_a); end
    n_cmp++; if (rd_a !== 8'h00)      begin n_bad++; $display("FAIL rst_data: %h required 00", rd_a); end
    n_cmp++; if ({pe_a, fe_a, oe_a} !== 3'b000)
      begin n_bad++; $display("FAIL rst_flags: %b required 000", {pe_a, fe_a, oe_a}); end
    n_cmp++; if ({tx_b, tx_c} !== 2'b11) begin n_bad++; $display("FAIL rst_tx_bc: %b required 11", {tx_b, tx_c}); end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_loop_8n1();
    sel = 2'd0;
    drv_en = 1'b0;
    push(8'hA5);
    push(8'h3C);
    find_start("a5");
    repeat (8) @(negedge clk);
    check_bits({3'b111, 8'hA5, 1'b0}, 10, "a5");
    repeat (16) @(negedge clk);
    check_bits({3'b111, 8'h3C, 1'b0}, 10, "3c");
    pop_check(8'hA5, "loop_rx_a5");
    pop_check(8'h3C, "loop_rx_3c");
    n_cmp++;
    if ({pe_v, fe_v, oe_v, empty_v} !== 4'b0001) begin
      n_bad++;
      $display("FAIL loop_flags: pe/fe/oe/empty=%b required 0001", {pe_v, fe_v, oe_v, empty_v});
    end
  endtask

  task automatic test_parity_tx();
    // 0x55 over 7 bits has four ones: even parity bit 0, odd parity bit 1
    sel = 2'd1;
    push(8'h55);
    push(8'h55);
    find_start("even");
    repeat (8) @(negedge clk);
    check_bits({1'b0, 2'b11, 1'b0, 7'h55, 1'b0}, 12, "even");
    pop_check(8'h55, "even_rx0");
    pop_check(8'h55, "even_rx1");
    n_cmp++;
    if ({pe_v, fe_v} !== 2'b00) begin n_bad++; $display("FAIL even_flags: %b required 00", {pe_v, fe_v}); end
    sel = 2'd2;
    push(8'h55);
    find_start("odd");
    repeat (8) @(negedge clk);
    check_bits({3'b111, 1'b1, 7'h55, 1'b0}, 11, "odd");
    pop_check(8'h55, "odd_rx");
    n_cmp++;
    if ({pe_v, fe_v} !== 2'b00) begin n_bad++; $display("FAIL odd_flags: %b required 00", {pe_v, fe_v}); end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_parity_rx_err();
    sel = 2'd2;
    drv = 1'b1;
    drv_en = 1'b1;
    repeat (20) @(negedge clk);
    // Odd parity of 0x01 is 0: first frame is correct, second carries a bad parity bit
    drive_bits({3'b111, 1'b0, 7'h01, 1'b0}, 11);
    pop_check(8'h01, "par_ok_rx");
    n_cmp++;
    if (pe_v !== 1'b0) begin n_bad++; $display("FAIL par_ok_flag: %b required 0", pe_v); end
    drive_bits({3'b111, 1'b1, 7'h01, 1'b0}, 11);
    pop_check(8'h01, "par_bad_rx");
    n_cmp++;
    if (pe_v !== 1'b1) begin n_bad++; $display("FAIL par_bad_flag: %b required 1", pe_v); end
    clear_errors();
    n_cmp++;
    if (pe_v !== 1'b0) begin n_bad++; $display("FAIL par_clr: %b required 0", pe_v); end
    drv_en = 1'b0;
  endtask

  task automatic test_frame_glitch();
    sel = 2'd0;
    drv = 1'b1;
    drv_en = 1'b1;
    clear_errors();
    repeat (20) @(negedge clk);
    drive_bits({3'b110, 8'h7E, 1'b0}, 10);
    repeat (16) @(negedge clk);
    pop_check(8'h7E, "frame_rx");
    n_cmp++;
    if (fe_v !== 1'b1) begin n_bad++; $display("FAIL frame_flag: %b required 1", fe_v); end
    clear_errors();
    drv = 1'b0;
    repeat (3) @(negedge clk);
    drv = 1'b1;
    repeat (60) @(negedge clk);
    n_cmp++;
    if (empty_v !== 1'b1 || cnt_v !== 5'd0 || fe_v !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch: empty=%b count=%0d fe=%b required 1/0/0", empty_v, cnt_v, fe_v);
    end
    drive_bits({3'b111, 8'h81, 1'b0}, 10);
    pop_check(8'h81, "after_glitch_rx");
  endtask

  task automatic test_overrun();
    logic [7:0] words [5];
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    sel = 2'd0;
    drv_en = 1'b1;
    clear_errors();
    for (int i = 0; i < 5; i++) drive_bits({3'b111, words[i], 1'b0}, 10);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (cnt_v !== 5'd4 || oe_v !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun: count=%0d oe=%b required 4/1", cnt_v, oe_v);
    end
    for (int i = 0; i < 4; i++) pop_check(words[i], "overrun_rx");
    n_cmp++;
    if (empty_v !== 1'b1) begin n_bad++; $display("FAIL overrun_drop: empty=%b required 1", empty_v); end
    drv_en = 1'b0;
    clear_errors();
  endtask

  task automatic test_tx_full();
    int k = 0;
    sel = 2'd0;
    drv_en = 1'b0;
    // Word 1 is popped on the clock after it lands, so five pushes fill four entries
    for (int i = 1; i <= 4; i++) push(8'(i));
    n_cmp++;
    if (full_v !== 1'b0) begin n_bad++; $display("FAIL tx_full_early: %b required 0", full_v); end
    push(8'h05);
    n_cmp++;
    if (full_v !== 1'b1) begin n_bad++; $display("FAIL tx_full_set: %b required 1", full_v); end
    push(8'h06);
    n_cmp++;
    if (full_v !== 1'b1) begin n_bad++; $display("FAIL tx_full_hold: %b required 1", full_v); end
    for (int i = 1; i <= 5; i++) pop_check(8'(i), "tx_full_rx");
    while (busy_v && k < 2000) begin
      @(negedge clk);
      k++;
    end
    repeat (100) @(negedge clk);
    n_cmp++;
    if (busy_v !== 1'b0 || empty_v !== 1'b1) begin
      n_bad++;
      $display("FAIL tx_full_drop: busy=%b empty=%b required 0/1", busy_v, empty_v);
    end
  endtask

  task automatic test_reset_midframe();
    sel = 2'd0;
    drv_en = 1'b0;
    push(8'h5A);
    repeat (200) @(negedge clk);
    n_cmp++;
    if (cnt_v !== 5'd1) begin n_bad++; $display("FAIL mid_pre_count: %0d required 1", cnt_v); end
    push(8'hC3);
    find_start("mid");
    repeat (8 + 16 * 3) @(negedge clk);
    n_cmp++;
    if (tx_v !== 1'b0) begin n_bad++; $display("FAIL mid_pre_tx: %b required 0", tx_v); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (tx_v !== 1'b1 || empty_v !== 1'b1 || cnt_v !== 5'd0 || busy_v !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: tx=%b empty=%b count=%0d busy=%b required 1/1/0/0",
               tx_v, empty_v, cnt_v, busy_v);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    push(8'hC3);
    pop_check(8'hC3, "mid_after_rx");
    n_cmp++;
    if ({pe_v, fe_v, oe_v} !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_after_flags: %b required 000", {pe_v, fe_v, oe_v});
    end
  endtask

  initial begin
    sel = 2'd0; drv_en = 1'b0; drv = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    err_clr = 1'b0; wr_data = 8'h00;
    test_reset();
    test_loop_8n1();
    test_parity_tx();
    test_parity_rx_err();
    test_frame_glitch();
    test_overrun();
    test_tx_full();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
